// File: rtl/counter_seq_pkg.sv
// Shared types and reset defaults for the counter profile sequencer.
package counter_seq_pkg;

  localparam int unsigned PROF_VAL_W   = 7;
  localparam int unsigned PROF_DWELL_W = 16;

  localparam int unsigned UP_DEF    = 110;
  localparam int unsigned DOWN_DEF  = 20;
  localparam int unsigned DWELL_DEF = 100;

  typedef enum logic [1:0] {
    IDLE,
    DWELL,
    PAUSE,
    DONE
  } state_t;

  typedef struct packed {
    logic [PROF_VAL_W-1:0]   up;
    logic [PROF_VAL_W-1:0]   down;
    logic                    select;
    logic [PROF_DWELL_W-1:0] dwell;
  } profile_t;

  localparam profile_t PROFILE_DEF = '{
    up:     PROF_VAL_W'(UP_DEF),
    down:   PROF_VAL_W'(DOWN_DEF),
    select: 1'b0,
    dwell:  PROF_DWELL_W'(DWELL_DEF)
  };

  // A programmed dwell of zero still shows the profile for one cycle.
  function automatic logic [PROF_DWELL_W-1:0] dwell_floor(input logic [PROF_DWELL_W-1:0] d);
    return (d == '0) ? PROF_DWELL_W'(1) : d;
  endfunction

endpackage

// File: rtl/counter_profile_sequencer_if.sv
// Configuration, control and Counter-side signals of the profile sequencer.
interface counter_profile_sequencer_if
  import counter_seq_pkg::*;
#(
  parameter int unsigned IDX_W   = 2,
  parameter int unsigned VAL_W   = PROF_VAL_W,
  parameter int unsigned DWELL_W = PROF_DWELL_W
);
  logic               cfg_we;
  logic [IDX_W-1:0]   cfg_addr;
  logic [VAL_W-1:0]   cfg_up;
  logic [VAL_W-1:0]   cfg_down;
  logic               cfg_select;
  logic [DWELL_W-1:0] cfg_dwell;
  logic [IDX_W-1:0]   seq_last;
  logic               loop_en;
  logic               start;
  logic               stop;
  logic               hold;
  logic [VAL_W-1:0]   count_up;
  logic [VAL_W-1:0]   count_down;
  logic               count_select;
  logic               apply;
  logic [IDX_W-1:0]   slot;
  logic               busy;
  logic               done;
  logic               cfg_err;

  modport master (
    output cfg_we, cfg_addr, cfg_up, cfg_down, cfg_select, cfg_dwell,
           seq_last, loop_en, start, stop, hold,
    input  count_up, count_down, count_select, apply, slot, busy, done, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_up, cfg_down, cfg_select, cfg_dwell,
           seq_last, loop_en, start, stop, hold,
    output count_up, count_down, count_select, apply, slot, busy, done, cfg_err
  );

endinterface

// File: rtl/counter_profile_table.sv
// Profile register file: validated writes, error pulse, combinational read.
module counter_profile_table
  import counter_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] addr,
  input  profile_t         wr,
  input  logic [IDX_W-1:0] rd_idx,
  output profile_t         rd,
  output logic             cfg_err
);

  profile_t mem [DEPTH];
  logic     wr_ok;

  assign wr_ok = wr.up > wr.down;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= PROFILE_DEF;
      end
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= we && !wr_ok;
      if (we && wr_ok) begin
        mem[addr] <= wr;
      end
    end
  end

  assign rd = mem[rd_idx];

endmodule

// File: rtl/counter_profile_sequencer.sv
// Steps through the profile table and drives each profile onto the Counter inputs.
module counter_profile_sequencer
  import counter_seq_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned VAL_W   = PROF_VAL_W,
  parameter int unsigned DWELL_W = PROF_DWELL_W,
  localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
  input logic                       clk,
  input logic                       rst,
  counter_profile_sequencer_if.slave bus
);

  state_t             state;
  state_t             state_nx;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   last_q;
  logic               loop_q;
  logic [DWELL_W-1:0] dwell_cnt;
  logic               load;
  logic               dec;
  logic [IDX_W-1:0]   load_idx;
  logic               apply_q;
  logic [VAL_W-1:0]   up_q;
  logic [VAL_W-1:0]   down_q;
  logic               select_q;
  profile_t           rd;
  profile_t           wr;

  assign wr = '{up: bus.cfg_up, down: bus.cfg_down, select: bus.cfg_select, dwell: bus.cfg_dwell};

  counter_profile_table #(
    .DEPTH(DEPTH)
  ) u_table (
    .clk    (clk),
    .rst    (rst),
    .we     (bus.cfg_we),
    .addr   (bus.cfg_addr),
    .wr     (wr),
    .rd_idx (load_idx),
    .rd     (rd),
    .cfg_err(bus.cfg_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    dec      = 1'b0;
    load_idx = '0;
    unique case (state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_nx = DWELL;
          load     = 1'b1;
        end
      end
      DWELL: begin
        if (bus.stop) begin
          state_nx = IDLE;
        end else if (bus.hold) begin
          state_nx = PAUSE;
        end else if (dwell_cnt > DWELL_W'(1)) begin
          dec = 1'b1;
        end else if (idx < last_q) begin
          load     = 1'b1;
          load_idx = idx + IDX_W'(1);
        end else if (loop_q) begin
          load = 1'b1;
        end else begin
          state_nx = DONE;
        end
      end
      PAUSE: begin
        if (bus.stop) begin
          state_nx = IDLE;
        end else if (!bus.hold) begin
          state_nx = DWELL;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == DWELL) || (state == PAUSE);
    bus.done = (state == DONE);
  end

  // The table read is taken before this edge's write lands, so a same-edge
  // write to the loaded slot only shows up on that slot's next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      up_q      <= VAL_W'(UP_DEF);
      down_q    <= VAL_W'(DOWN_DEF);
      select_q  <= 1'b0;
      idx       <= '0;
      dwell_cnt <= '0;
      apply_q   <= 1'b0;
      last_q    <= '0;
      loop_q    <= 1'b0;
    end else begin
      apply_q <= load;
      if (load) begin
        up_q      <= rd.up;
        down_q    <= rd.down;
        select_q  <= rd.select;
        idx       <= load_idx;
        dwell_cnt <= dwell_floor(rd.dwell);
      end else if (dec) begin
        dwell_cnt <= dwell_cnt - DWELL_W'(1);
      end
      if (state == IDLE && bus.start && !bus.stop) begin
        last_q <= bus.seq_last;
        loop_q <= bus.loop_en;
      end
    end
  end

  assign bus.count_up     = up_q;
  assign bus.count_down   = down_q;
  assign bus.count_select = select_q;
  assign bus.apply        = apply_q;
  assign bus.slot         = idx;

endmodule

// File: tb/tb_counter_profile_sequencer.sv
// Directed bench for counter_profile_sequencer with hand-computed expectations.
module tb_counter_profile_sequencer;
  import counter_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  counter_profile_sequencer_if #(.IDX_W(2), .VAL_W(7), .DWELL_W(16)) bus ();

  counter_profile_sequencer #(
    .DEPTH  (4),
    .VAL_W  (7),
    .DWELL_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int a, input int up, input int down, input int sel, input int dwell);
    bus.cfg_we     = 1'b1;
    bus.cfg_addr   = 2'(a);
    bus.cfg_up     = 7'(up);
    bus.cfg_down   = 7'(down);
    bus.cfg_select = 1'(sel);
    bus.cfg_dwell  = 16'(dwell);
    tick();
    bus.cfg_we = 1'b0;
  endtask

  // Leaves the bench in the first cycle the slot-0 profile is visible.
  task automatic start_run(input int last, input logic loop);
    bus.seq_last = 2'(last);
    bus.loop_en  = loop;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    int exp_slot;
    int ph;
    int vis0;
    logic apply_seen;

    rst            = 1'b1;
    bus.cfg_we     = 1'b0;
    bus.cfg_addr   = '0;
    bus.cfg_up     = '0;
    bus.cfg_down   = '0;
    bus.cfg_select = 1'b0;
    bus.cfg_dwell  = '0;
    bus.seq_last   = '0;
    bus.loop_en    = 1'b0;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.hold       = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state and quiet idle
    apply_seen = 1'b0;
    repeat (20) begin
      tick();
      if (bus.apply) apply_seen = 1'b1;
    end
    chk("rst_apply_seen", 32'(apply_seen), 0);
    chk("rst_count_up", 32'(bus.count_up), 110);
    chk("rst_count_down", 32'(bus.count_down), 20);
    chk("rst_select", 32'(bus.count_select), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_slot", 32'(bus.slot), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_cfg_err", 32'(bus.cfg_err), 0);

    // start together with stop stays idle
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk("startstop_busy", 32'(bus.busy), 0);
    chk("startstop_apply", 32'(bus.apply), 0);

    // Two-slot non-looping run
    cfg_write(0, 100, 10, 0, 5);
    chk("wr0_cfg_err", 32'(bus.cfg_err), 0);
    cfg_write(1, 60, 30, 1, 3);
    chk("wr1_cfg_err", 32'(bus.cfg_err), 0);
    start_run(1, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      exp_slot = (c <= 5) ? 0 : 1;
      chk($sformatf("run_slot_c%0d", c), 32'(bus.slot), 32'(exp_slot));
      chk($sformatf("run_apply_c%0d", c), 32'(bus.apply), 32'(c == 1 || c == 6));
      chk($sformatf("run_busy_c%0d", c), 32'(bus.busy), 32'(c <= 8));
      chk($sformatf("run_done_c%0d", c), 32'(bus.done), 32'(c == 9));
      chk($sformatf("run_up_c%0d", c), 32'(bus.count_up), (exp_slot == 1) ? 60 : 100);
      chk($sformatf("run_sel_c%0d", c), 32'(bus.count_select), 32'(exp_slot));
      if (c < 10) tick();
    end
    chk("run_hold_down", 32'(bus.count_down), 30);

    // Looping run, with a start while busy that must be ignored
    start_run(1, 1'b1);
    for (int c = 1; c <= 30; c++) begin
      ph = (c - 1) % 8;
      chk($sformatf("loop_slot_c%0d", c), 32'(bus.slot), 32'(ph >= 5));
      chk($sformatf("loop_apply_c%0d", c), 32'(bus.apply), 32'(ph == 0 || ph == 5));
      chk($sformatf("loop_busy_c%0d", c), 32'(bus.busy), 1);
      chk($sformatf("loop_done_c%0d", c), 32'(bus.done), 0);
      bus.start = (c == 10);
      if (c < 30) tick();
    end
    bus.start = 1'b0;
    bus.stop  = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("stop_busy", 32'(bus.busy), 0);
    chk("stop_apply", 32'(bus.apply), 0);
    chk("stop_done", 32'(bus.done), 0);
    chk("stop_slot", 32'(bus.slot), 1);
    chk("stop_up", 32'(bus.count_up), 60);
    chk("stop_down", 32'(bus.count_down), 30);
    chk("stop_sel", 32'(bus.count_select), 1);
    tick();
    chk("stop_done_after", 32'(bus.done), 0);

    // Rejected write, then zero dwell
    cfg_write(2, 20, 20, 0, 4);
    chk("bad_cfg_err", 32'(bus.cfg_err), 1);
    tick();
    chk("bad_cfg_err_clear", 32'(bus.cfg_err), 0);
    cfg_write(0, 90, 5, 1, 0);
    chk("dw0_cfg_err", 32'(bus.cfg_err), 0);
    start_run(2, 1'b0);
    for (int c = 1; c <= 106; c++) begin
      exp_slot = (c == 1) ? 0 : (c <= 4) ? 1 : 2;
      chk($sformatf("dw0_slot_c%0d", c), 32'(bus.slot), 32'(exp_slot));
      chk($sformatf("dw0_apply_c%0d", c), 32'(bus.apply), 32'(c == 1 || c == 2 || c == 5));
      chk($sformatf("dw0_busy_c%0d", c), 32'(bus.busy), 32'(c <= 104));
      chk($sformatf("dw0_done_c%0d", c), 32'(bus.done), 32'(c == 105));
      if (c == 1) begin
        chk("dw0_up_c1", 32'(bus.count_up), 90);
        chk("dw0_sel_c1", 32'(bus.count_select), 1);
      end
      if (c == 5) begin
        chk("slot2_up", 32'(bus.count_up), 110);
        chk("slot2_down", 32'(bus.count_down), 20);
        chk("slot2_sel", 32'(bus.count_select), 0);
      end
      if (c < 106) tick();
    end

    // Hold for 7 cycles from the third cycle of a 5-cycle dwell; the cycle
    // leaving PAUSE does not count down, so slot 0 shows for 13 cycles.
    cfg_write(0, 100, 10, 0, 5);
    start_run(1, 1'b0);
    vis0 = 0;
    for (int c = 1; c <= 14; c++) begin
      if (bus.slot == 2'd0) vis0++;
      chk($sformatf("hold_slot_c%0d", c), 32'(bus.slot), 32'(c > 13));
      chk($sformatf("hold_apply_c%0d", c), 32'(bus.apply), 32'(c == 1 || c == 14));
      chk($sformatf("hold_busy_c%0d", c), 32'(bus.busy), 1);
      bus.hold = (c >= 3 && c <= 9);
      if (c < 14) tick();
    end
    bus.hold = 1'b0;
    chk("hold_vis0", 32'(vis0), 13);
    repeat (3) tick();
    chk("hold_done", 32'(bus.done), 1);
    chk("hold_slot_end", 32'(bus.slot), 1);
    tick();
    chk("hold_idle", 32'(bus.busy), 0);

    // Reset in the middle of slot 1 restores outputs and table
    start_run(1, 1'b0);
    repeat (6) tick();
    chk("mid_slot", 32'(bus.slot), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", 32'(bus.busy), 0);
    chk("mrst_up", 32'(bus.count_up), 110);
    chk("mrst_down", 32'(bus.count_down), 20);
    chk("mrst_sel", 32'(bus.count_select), 0);
    chk("mrst_slot", 32'(bus.slot), 0);
    chk("mrst_apply", 32'(bus.apply), 0);
    start_run(1, 1'b0);
    chk("def_apply", 32'(bus.apply), 1);
    chk("def_up", 32'(bus.count_up), 110);
    chk("def_down", 32'(bus.count_down), 20);
    chk("def_sel", 32'(bus.count_select), 0);
    repeat (99) tick();
    chk("def_slot_c100", 32'(bus.slot), 0);
    chk("def_apply_c100", 32'(bus.apply), 0);
    tick();
    chk("def_slot_c101", 32'(bus.slot), 1);
    chk("def_apply_c101", 32'(bus.apply), 1);
    chk("def_up_c101", 32'(bus.count_up), 110);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("def_stop_busy", 32'(bus.busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
